multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle RV32 core. Sequences FETCH/DECODE/EXEC/MEM/WB for the
//  supported subset (R-type, I-type ALU, LW, SW, B-type), drives the datapath mux selects, and
//  tells the immediate generator which format to produce via imm_sel. Owns the memory req/ready
//  handshake with a wait timeout, and traps on illegal opcodes or bus timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive cycles waiting on mem_ready in FETCH/MEM before trapping (>=1)
// PORTS
//  clk            in   1   clock; all state changes on rising edge
//  reset          in   1   asynchronous, active-high reset
//  instr          in   32  current IR contents (valid from DECODE onward)
//  mem_ready      in   1   memory completes the current access this cycle
//  branch_taken   in   1   branch comparator result from ALU (valid in EXEC)
//  pc_write       out  1   load PC this cycle
//  pc_src         out  1   0 = ALU result (PC+4), 1 = branch target (old_pc + imm)
//  ir_write       out  1   load IR and old_pc this cycle
//  iord           out  1   memory address select: 0 = PC, 1 = ALU result
//  mem_req        out  1   memory access request
//  mem_we         out  1   write strobe (qualified by mem_req)
//  imm_sel        out  2   00 I-format, 01 S-format, 10 B-format, 11 zero
//  alu_src_a      out  1   0 = PC, 1 = rs1
//  alu_src_b      out  2   00 rs2, 01 constant 4, 10 immediate
//  alu_op         out  2   00 ADD, 01 branch compare, 10 decode from funct3/funct7
//  reg_write      out  1   register file write enable
//  mem_to_reg     out  1   writeback source: 0 = ALU result, 1 = memory data
//  instr_done     out  1   one-cycle pulse on the last cycle of each retired instruction
//  illegal_instr  out  1   sticky: trap entered on unsupported opcode/funct3
//  bus_err        out  1   sticky: trap entered on mem_ready timeout
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Reset -> FETCH, wait counter 0,
//    sticky flags 0. While reset is high every output is 0. Reset mid-instruction abandons it.
//  - Outputs are decoded from state (and mem_ready/branch_taken where noted); unlisted outputs 0.
//  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. If mem_ready: ir_write=1,
//    pc_write=1, pc_src=0, -> DECODE; else stay.
//  - DECODE: imm_sel from instr[6:0]: 0010011/0000011 -> 00, 0100011 -> 01, 1100011 -> 10,
//    0110011 -> 11. Legal: those five opcodes; LW/SW additionally need funct3==010.
//    Legal -> EXEC; illegal -> TRAP with illegal_instr set.
//  - imm_sel holds its decoded value in DECODE, EXEC, MEM and WB (from instr); 11 in FETCH/TRAP.
//  - EXEC: alu_src_a=1. R: alu_src_b=00, alu_op=10 -> WB. I-ALU: alu_src_b=10, alu_op=10 -> WB.
//    LW/SW: alu_src_b=10, alu_op=00 -> MEM. B: alu_src_b=00, alu_op=01; if branch_taken
//    pc_write=1, pc_src=1; instr_done=1; -> FETCH.
//  - MEM: mem_req=1, iord=1, mem_we=1 for SW. If mem_ready: SW -> FETCH with instr_done=1;
//    LW -> WB. Else stay. alu selects held as in EXEC so the address is stable.
//  - WB: reg_write=1, mem_to_reg=1 for LW else 0, instr_done=1, -> FETCH.
//  - TRAP: absorbing until reset; all strobes 0, flags hold.
//  - Wait counter, width $clog2(MEM_TIMEOUT+1): clears on every state change; in FETCH/MEM
//    increments each cycle mem_ready=0. If mem_ready=0 while counter==MEM_TIMEOUT-1 -> TRAP,
//    bus_err set. mem_ready in the same cycle always wins (access completes, no trap).
//  - Latency with zero-wait memory: B 3 cycles, R/I/SW 4, LW 5. Each memory wait adds 1.
//  - Exactly one of pc_write/reg_write/mem_we-write side effects per legal step as listed; no
//    strobe is ever asserted in TRAP or during reset.
// TESTING
//  1. ADDI x1,x0,5 (0x00500093), mem_ready=1 -> states 0,1,2,4; imm_sel=00 from DECODE; reg_write
//     and instr_done in cycle 4, mem_to_reg=0.
//  2. LW x2,0(x1) (0x0000A103), mem_ready low 3 cycles in MEM -> mem_req,iord held 4 MEM cycles;
//     then WB with reg_write=1, mem_to_reg=1; total 8 cycles.
//  3. BEQ x0,x0,+8 (0x00000463), branch_taken=1 -> EXEC pc_write=1, pc_src=1, imm_sel=10,
//     instr_done=1; back in FETCH on cycle 4. With branch_taken=0 -> no pc_write in EXEC.
//  4. SW (0x0020A023) -> MEM with mem_we=1, imm_sel=01, instr_done on mem_ready, no reg_write.
//  5. instr 0x0000007F -> TRAP after DECODE, illegal_instr=1 held for 20 cycles, no strobes;
//     LW with funct3=000 (0x00008103) also traps.
//  6. MEM_TIMEOUT=16: mem_ready=0 in FETCH -> TRAP after 16 cycles, bus_err=1; ready on 16th
//     cycle -> normal DECODE; reset asserted mid-EXEC -> all outputs 0, FETCH after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB for R-type, I-type ALU, LW, SW and B-type instructions.
// It drives the datapath selects and the immediate format select.
// It owns the memory req/ready handshake, including a bounded wait.
// It traps on an illegal opcode/funct3 or on a bus timeout; the trap holds until reset.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  imm_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic        illegal_instr,
    output logic        bus_err
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_lw, is_sw, is_b, legal;
    logic [1:0] imm_dec;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // The remaining IR fields belong to the datapath, not to control.
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    // Instruction class and immediate format decoded from the IR
    always_comb begin
        is_r    = (opcode == OpReg);
        is_i    = (opcode == OpImm);
        is_lw   = (opcode == OpLoad);
        is_sw   = (opcode == OpStore);
        is_b    = (opcode == OpBranch);
        // Only word-sized loads/stores are supported.
        legal   = is_r | is_i | is_b | ((is_lw | is_sw) & (funct3 == 3'b010));
        imm_dec = 2'b11;
        if (is_i || is_lw) begin
            imm_dec = 2'b00;
        end else if (is_sw) begin
            imm_dec = 2'b01;
        end else if (is_b) begin
            imm_dec = 2'b10;
        end
    end

    // Next state, memory wait counter and sticky trap causes
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        unique case (state_q)
            StFetch, StMem: begin
                // A completing access always beats the timeout.
                if (mem_ready) begin
                    if (state_q == StFetch) begin
                        state_d = StDecode;
                    end else if (is_sw) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_q == WaitLast) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                if (is_b) begin
                    state_d = StFetch;
                end else if (is_lw || is_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Datapath controls decoded from state; everything is forced low while reset is high
    always_comb begin
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        imm_sel       = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        bus_err       = 1'b0;
        if (!reset) begin
            illegal_instr = illegal_q;
            bus_err       = bus_err_q;
            imm_sel       = imm_dec;
            unique case (state_q)
                StFetch: begin
                    imm_sel   = 2'b11;
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                StDecode: begin
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    if (is_r) begin
                        alu_op = 2'b10;
                    end else if (is_i) begin
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                    end else if (is_lw || is_sw) begin
                        alu_src_b = 2'b10;
                    end else begin
                        alu_op     = 2'b01;
                        instr_done = 1'b1;
                        if (branch_taken) begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                    end
                end
                StMem: begin
                    // Address selects held from EXEC so the ALU output stays stable.
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_we    = is_sw;
                    if (mem_ready && is_sw) begin
                        instr_done = 1'b1;
                    end
                end
                StWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                    instr_done = 1'b1;
                end
                default: begin
                    imm_sel = 2'b11;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output traces built from
// instruction class and memory wait schedule, compared every cycle, plus literal latencies.
module tb_multicycle_ctrl;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        pc_write, pc_src, ir_write, iord, mem_req, mem_we;
    logic [1:0]  imm_sel, alu_src_b, alu_op;
    logic        alu_src_a, reg_write, mem_to_reg, instr_done, illegal_instr, bus_err;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ir_write     (ir_write),
        .iord         (iord),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .instr_done   (instr_done),
        .illegal_instr(illegal_instr),
        .bus_err      (bus_err)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic [1:0] imm_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal_instr;
        logic       bus_err;
    } outv_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        tkn;
        logic [31:0] ins;
        outv_t       exp;
    } step_t;

    outv_t act;
    assign act = {pc_write, pc_src, ir_write, iord, mem_req, mem_we, imm_sel, alu_src_a,
                  alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, illegal_instr, bus_err};

    step_t q[$];
    int    total = 0;
    int    bad = 0;
    bit    ill_m = 1'b0;
    bit    be_m = 1'b0;

    function automatic outv_t base_v();
        outv_t v;
        v = '0;
        v.illegal_instr = ill_m;
        v.bus_err = be_m;
        return v;
    endfunction

    // Immediate format a given instruction word calls for.
    function automatic logic [1:0] fmt_of(input logic [31:0] ins);
        case (ins[6:0])
            7'b0010011, 7'b0000011: return 2'b00;
            7'b0100011:             return 2'b01;
            7'b1100011:             return 2'b10;
            default:                return 2'b11;
        endcase
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic tkn,
                        input logic [31:0] ins, input outv_t exp);
        step_t s;
        s.rst = rst; s.rdy = rdy; s.tkn = tkn; s.ins = ins; s.exp = exp;
        q.push_back(s);
    endtask

    task automatic gen_reset(input int n);
        ill_m = 1'b0;
        be_m = 1'b0;
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b1, 32'h0, '0);
    endtask

    task automatic gen_trap(input logic [31:0] ins, input int n);
        outv_t v;
        for (int i = 0; i < n; i++) begin
            v = base_v();
            v.imm_sel = 2'b11;
            push(1'b0, logic'(i % 2), 1'b1, ins, v);
        end
    endtask

    // Expected trace for one instruction with fw fetch waits and mw data-access waits.
    task automatic gen_instr(input logic [31:0] ins, input int fw, input int mw, input logic tkn);
        outv_t v;
        logic [6:0] op;
        bit is_r, is_i, is_lw, is_sw, is_b, ok;
        op = ins[6:0];
        is_r = (op == 7'b0110011); is_i = (op == 7'b0010011); is_lw = (op == 7'b0000011);
        is_sw = (op == 7'b0100011); is_b = (op == 7'b1100011);
        ok = is_r || is_i || is_b || ((is_lw || is_sw) && ins[14:12] == 3'b010);
        // FETCH
        for (int i = 0; i < fw && i < int'(TMO); i++) begin
            v = base_v(); v.mem_req = 1; v.alu_src_b = 2'b01; v.imm_sel = 2'b11;
            push(1'b0, 1'b0, tkn, ins, v);
        end
        if (fw >= int'(TMO)) begin be_m = 1'b1; return; end
        v = base_v(); v.mem_req = 1; v.alu_src_b = 2'b01; v.imm_sel = 2'b11;
        v.ir_write = 1; v.pc_write = 1;
        push(1'b0, 1'b1, tkn, ins, v);
        // DECODE
        v = base_v(); v.imm_sel = fmt_of(ins);
        push(1'b0, 1'b1, tkn, ins, v);
        if (!ok) begin ill_m = 1'b1; return; end
        // EXEC
        v = base_v(); v.imm_sel = fmt_of(ins); v.alu_src_a = 1;
        if (is_r) v.alu_op = 2'b10;
        else if (is_i) begin v.alu_src_b = 2'b10; v.alu_op = 2'b10; end
        else if (is_lw || is_sw) v.alu_src_b = 2'b10;
        else begin
            v.alu_op = 2'b01; v.instr_done = 1; v.pc_write = tkn; v.pc_src = tkn;
        end
        push(1'b0, 1'b1, tkn, ins, v);
        if (is_b) return;
        // MEM
        if (is_lw || is_sw) begin
            for (int i = 0; i <= mw && i < int'(TMO); i++) begin
                v = base_v(); v.imm_sel = fmt_of(ins); v.alu_src_a = 1; v.alu_src_b = 2'b10;
                v.mem_req = 1; v.iord = 1; v.mem_we = is_sw;
                v.instr_done = (i == mw) && is_sw;
                push(1'b0, logic'(i == mw), tkn, ins, v);
            end
            if (mw >= int'(TMO)) begin be_m = 1'b1; return; end
            if (is_sw) return;
        end
        // WB
        v = base_v(); v.imm_sel = fmt_of(ins); v.reg_write = 1; v.mem_to_reg = is_lw;
        v.instr_done = 1;
        push(1'b0, 1'b1, tkn, ins, v);
    endtask

    // Drive queued steps and compare outputs each cycle; exp_lat>0 pins instr_done position.
    task automatic run(input string name, input int exp_lat);
        step_t s;
        int n;
        int done_at;
        n = 0;
        done_at = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            reset = s.rst; mem_ready = s.rdy; branch_taken = s.tkn; instr = s.ins;
            #2;
            n++;
            total++;
            if (act !== s.exp) begin
                bad++;
                $display("FAIL %s step %0d: outputs got %h want %h", name, n, act, s.exp);
            end
            if (act.instr_done === 1'b1 && done_at == 0) done_at = n;
        end
        if (exp_lat > 0) begin
            total++;
            if (done_at != exp_lat) begin
                bad++;
                $display("FAIL %s latency: got %0d want %0d", name, done_at, exp_lat);
            end
        end
    endtask

    initial begin
        int base;
        gen_reset(2);                                   run("reset", 0);
        gen_instr(32'h00500093, 0, 0, 1'b1);            run("addi", 4);
        gen_instr(32'h0000A103, 0, 3, 1'b0);            run("lw_wait3", 8);
        gen_instr(32'h00000463, 0, 0, 1'b1);            run("beq_taken", 3);
        gen_instr(32'h00000463, 0, 0, 1'b0);            run("beq_not_taken", 3);
        gen_instr(32'h0020A023, 1, 2, 1'b0);            run("sw_waits", 7);
        gen_instr(32'h002081B3, 2, 0, 1'b1);            run("add_fwait2", 6);
        gen_instr(32'h0000007F, 0, 0, 1'b0);
        gen_trap(32'h0000007F, 20);                     run("illegal_opcode", 0);
        gen_reset(1);                                   run("reset_after_illegal", 0);
        gen_instr(32'h00008103, 0, 0, 1'b0);
        gen_trap(32'h00008103, 5);                      run("lw_bad_funct3", 0);
        gen_reset(1);                                   run("reset_after_funct3", 0);
        gen_instr(32'h00500093, int'(TMO), 0, 1'b0);
        gen_trap(32'h00500093, 5);                      run("fetch_timeout", 0);
        gen_reset(1);                                   run("reset_after_fetch_to", 0);
        gen_instr(32'h00500093, int'(TMO) - 1, 0, 1'b0); run("fetch_ready_last", 19);
        gen_instr(32'h0000A103, 0, int'(TMO), 1'b0);
        gen_trap(32'h0000A103, 4);                      run("mem_timeout", 0);
        gen_reset(1);                                   run("reset_after_mem_to", 0);
        // Reset lands in the EXEC cycle and abandons the instruction.
        base = q.size();
        gen_instr(32'h00500093, 0, 0, 1'b0);
        while (q.size() > base + 2) void'(q.pop_back());
        gen_reset(2);                                   run("reset_mid_exec", 0);
        gen_instr(32'h00500093, 0, 0, 1'b0);            run("addi_after_reset", 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
